// File: rtl/div_pkg.sv
// div_pkg: shared defaults and FSM encoding for the divider arbiter.
package div_pkg;
  localparam int W_DEF = 10;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if: requester, response and divider-side signals of the divider arbiter.
interface div_arbiter_if
  import div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = W_DEF,
  parameter int IDW = 2
);
  logic [NREQ-1:0] req, gnt;
  logic [NREQ*W-1:0] a_in, b_in;
  logic resp_valid, resp_ov, resp_dvz, resp_to;
  logic [IDW-1:0] resp_id;
  logic [W-1:0] resp_q, div_a, div_b, div_q;
  logic div_start, div_busy, div_valid, div_ov, div_dvz;
  modport master (
    input req, a_in, b_in, div_q, div_busy, div_valid, div_ov, div_dvz,
    output gnt, resp_valid, resp_id, resp_q, resp_ov, resp_dvz, resp_to, div_start, div_a, div_b
  );
  modport slave (
    output req, a_in, b_in, div_q, div_busy, div_valid, div_ov, div_dvz,
    input gnt, resp_valid, resp_id, resp_q, resp_ov, resp_dvz, resp_to, div_start, div_a, div_b
  );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request bit at or above ptr, wrapping, as one-hot plus index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [IDW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    any = |req;
    // scan farthest-first so the nearest set bit to ptr is written last
    for (int i = NREQ - 1; i >= 0; i--) begin
      j = IDW'((int'(ptr) + i) % NREQ);
      if (req[j]) idx = j;
    end
    onehot = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sharing of one iterative divider among NREQ requesters,
// with a watchdog that aborts an operation the divider never completes.
module div_arbiter
  import div_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W = W_DEF,
  parameter int IDW = 2,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic clk,
  input logic rst,
  div_arbiter_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT);
  state_t state, nxt;
  logic [IDW-1:0] rr_ptr, cur_id, pick_idx;
  logic [NREQ-1:0] pick_oh;
  logic pick_any, done, expired;
  logic [WDW-1:0] wd;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req(bus.req), .ptr(rr_ptr), .onehot(pick_oh), .idx(pick_idx), .any(pick_any)
  );

  assign done = bus.div_valid | bus.div_dvz | bus.div_ov;
  assign expired = wd == WDW'(TIMEOUT - 1);
  // gnt is gated by reset so every output reads zero while rst is low
  assign bus.gnt = (state == IDLE && rst) ? pick_oh : '0;
  assign bus.div_start = state == ISSUE;
  assign bus.resp_valid = state == RESP;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  nxt = pick_any ? ISSUE : IDLE;
      ISSUE: nxt = WAIT;
      WAIT:  nxt = (done || expired) ? RESP : WAIT;
      RESP:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= '0;
      cur_id <= '0;
      wd <= '0;
      bus.div_a <= '0;
      bus.div_b <= '0;
      bus.resp_id <= '0;
      bus.resp_q <= '0;
      bus.resp_ov <= 1'b0;
      bus.resp_dvz <= 1'b0;
      bus.resp_to <= 1'b0;
    end else begin
      if (state == IDLE && pick_any) begin
        cur_id <= pick_idx;
        bus.div_a <= bus.a_in[pick_idx*W +: W];
        bus.div_b <= bus.b_in[pick_idx*W +: W];
      end
      if (state == ISSUE) wd <= '0;
      if (state == WAIT) begin
        wd <= wd + 1'b1;
        // completion beats an expiry landing in the same cycle
        if (done || expired) begin
          bus.resp_id <= cur_id;
          bus.resp_q <= done ? bus.div_q : '0;
          bus.resp_ov <= done & bus.div_ov;
          bus.resp_dvz <= done & bus.div_dvz;
          bus.resp_to <= !done;
        end
      end
      if (state == RESP) rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
    end
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized and directed bench with a timeline model of the arbiter
// and a behavioural divider driving the divider-side inputs.
module tb_div_arbiter;
  localparam int NREQ = 4, W = 10, IDW = 2, TIMEOUT = 64;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  div_arbiter_if #(.NREQ(NREQ), .W(W), .IDW(IDW)) bif ();
  div_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bif));

  logic [NREQ-1:0] req_r = '0;
  logic [W-1:0] a_r [NREQ];
  logic [W-1:0] b_r [NREQ];
  logic [W-1:0] dq = '0;
  logic dbusy = 0, dvalid = 0, dov = 0, ddvz = 0;
  assign bif.req = req_r;
  assign bif.div_q = dq;
  assign bif.div_busy = dbusy;
  assign bif.div_valid = dvalid;
  assign bif.div_ov = dov;
  assign bif.div_dvz = ddvz;
  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign bif.a_in[g*W +: W] = a_r[g];
    assign bif.b_in[g*W +: W] = b_r[g];
  end

  int n_pass = 0, n_total = 0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
  endtask

  // knobs for the divider behaviour chosen at each grant
  int force_lat = -1;
  bit never_mode = 0, ov_en = 0, hold = 0;

  // timeline model: each grant fixes the cycles of start, completion and response
  int cyc = 0;
  int t_gnt = -10, t_done = -10, t_resp = -10, free_at = 0, ptr = 0;
  bit fire = 0;
  logic [W-1:0] op_a, op_b, op_q;
  bit op_ov, op_dvz, op_to;
  int op_id;
  logic [W-1:0] ex_a = '0, ex_b = '0, ex_q = '0;
  int ex_id = 0;
  bit ex_ov = 0, ex_dvz = 0, ex_to = 0;

  always @(negedge clk) begin
    logic [NREQ-1:0] eg;
    int w, lat;
    eg = '0;
    if (!rst) begin
      t_gnt = -10; t_done = -10; t_resp = -10; free_at = 0; ptr = 0; fire = 0;
      ex_a = '0; ex_b = '0; ex_q = '0; ex_id = 0; ex_ov = 0; ex_dvz = 0; ex_to = 0;
    end else begin
      if (cyc == t_gnt + 1) begin ex_a = op_a; ex_b = op_b; end
      if (cyc == t_resp) begin ex_q = op_q; ex_id = op_id; ex_ov = op_ov; ex_dvz = op_dvz; ex_to = op_to; end
      if (cyc >= free_at && req_r != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_r[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        eg[w] = 1'b1;
        t_gnt = cyc; op_id = w; op_a = a_r[w]; op_b = b_r[w]; ptr = (w + 1) % NREQ;
        lat = never_mode ? TIMEOUT : force_lat >= 0 ? force_lat :
              ($urandom_range(0, 19) == 0) ? int'($urandom_range(TIMEOUT - 3, TIMEOUT + 2)) : int'($urandom_range(0, 5));
        if (lat >= TIMEOUT) begin
          fire = 0; t_done = cyc + 2 + TIMEOUT - 1; op_q = '0; op_ov = 0; op_dvz = 0; op_to = 1;
        end else begin
          fire = 1; t_done = cyc + 2 + lat; op_to = 0;
          if (op_b == '0) begin op_q = '0; op_ov = 0; op_dvz = 1; end
          else if (ov_en && $urandom_range(0, 5) == 0) begin op_q = W'($urandom); op_ov = 1; op_dvz = 0; end
          else begin op_q = op_a / op_b; op_ov = 0; op_dvz = 0; end
        end
        t_resp = t_done + 1;
        free_at = t_resp + 1;
      end
    end
    check("gnt", bif.gnt, eg);
    check("div_start", bif.div_start, rst && cyc == t_gnt + 1);
    check("resp_valid", bif.resp_valid, rst && cyc == t_resp);
    check("resp_id", bif.resp_id, ex_id);
    check("resp_q", bif.resp_q, ex_q);
    check("resp_ov", bif.resp_ov, ex_ov);
    check("resp_dvz", bif.resp_dvz, ex_dvz);
    check("resp_to", bif.resp_to, ex_to);
    check("div_a", bif.div_a, ex_a);
    check("div_b", bif.div_b, ex_b);
  end

  // behavioural divider: one completion pulse when planned, noise only outside WAIT
  always @(posedge clk) begin
    cyc++;
    #1;
    if (fire && cyc == t_done) begin
      dq = op_q; dvalid = !op_dvz; dov = op_ov; ddvz = op_dvz;
    end else if (!(cyc >= t_gnt + 2 && cyc <= t_done) && $urandom_range(0, 7) == 0) begin
      dq = W'($urandom); dvalid = 1'($urandom); dov = 1'($urandom); ddvz = 1'($urandom);
    end else begin
      dq = W'($urandom); dvalid = 0; dov = 0; ddvz = 0;
    end
    dbusy = cyc > t_gnt && cyc <= t_done;
  end

  logic [NREQ-1:0] last_gnt;
  logic last_rv, last_start, last_ov, last_dvz, last_to;
  logic [IDW-1:0] last_id;
  logic [W-1:0] last_q, last_da;

  task automatic step();
    @(negedge clk);
    last_gnt = bif.gnt; last_rv = bif.resp_valid; last_start = bif.div_start;
    last_id = bif.resp_id; last_q = bif.resp_q; last_ov = bif.resp_ov;
    last_dvz = bif.resp_dvz; last_to = bif.resp_to; last_da = bif.div_a;
    @(posedge clk);
    #1;
    if (!hold) req_r = req_r & ~last_gnt;
  endtask

  task automatic issue(int i, logic [W-1:0] a, logic [W-1:0] b);
    a_r[i] = a; b_r[i] = b; req_r[i] = 1'b1;
  endtask

  task automatic wait_resp(string name);
    int n = 0;
    do begin step(); n++; end while (!last_rv && n < 300);
    check(name, last_rv, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (cyc <= free_at && n < 200) begin step(); n++; end
  endtask

  initial begin
    int n;
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NREQ; i++) begin a_r[i] = '0; b_r[i] = '0; end
    repeat (3) step();
    check("reset gnt", last_gnt, 0);
    check("reset resp_valid", last_rv, 0);
    rst = 1;

    force_lat = 3;
    issue(0, 10'd848, 10'd24);
    wait_resp("t1 resp seen");
    check("t1 id", last_id, 0);
    check("t1 q", last_q, 35);
    check("t1 ov", last_ov, 0);
    check("t1 dvz", last_dvz, 0);

    issue(1, 10'd32, 10'd16);
    n = 0;
    do begin step(); n++; end while (last_gnt == '0 && n < 50);
    check("t2 gnt", last_gnt, 4'b0010);
    step();
    check("t2 start one cycle after gnt", last_start, 1);
    wait_resp("t2 resp seen");
    check("t2 id", last_id, 1);
    check("t2 q", last_q, 2);

    issue(2, 10'd848, 10'd0);
    wait_resp("t3 resp seen");
    check("t3 id", last_id, 2);
    check("t3 dvz", last_dvz, 1);
    check("t3 to", last_to, 0);

    rst = 0; req_r = '0;
    step(); step();
    for (int i = 0; i < NREQ; i++) begin a_r[i] = W'(100 + i); b_r[i] = W'(i + 1); end
    force_lat = 1; hold = 1; req_r = '1; rst = 1;
    for (int k = 0; k < 5; k++) begin
      wait_resp("t4 resp seen");
      check("t4 rr order", last_id, order[k]);
    end
    hold = 0; req_r = '0;
    drain();

    never_mode = 1;
    issue(0, 10'd100, 10'd7);
    wait_resp("t5 timeout resp seen");
    check("t5 to", last_to, 1);
    check("t5 q", last_q, 0);
    never_mode = 0; force_lat = 2;
    issue(1, 10'd100, 10'd7);
    wait_resp("t5 next resp seen");
    check("t5 next id", last_id, 1);
    check("t5 next to", last_to, 0);
    check("t5 next q", last_q, 14);

    force_lat = 20;
    issue(1, 10'd500, 10'd5);
    n = 0;
    do begin step(); n++; end while (!last_start && n < 50);
    repeat (3) step();
    rst = 0; req_r = '0;
    step();
    check("t6 reset start", last_start, 0);
    check("t6 reset resp_valid", last_rv, 0);
    check("t6 reset div_a", last_da, 0);
    step();
    rst = 1; force_lat = 2;
    issue(3, 10'd99, 10'd9);
    wait_resp("t6 resp seen");
    check("t6 id", last_id, 3);
    check("t6 q", last_q, 11);

    force_lat = -1; ov_en = 1;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_r[i] && $urandom_range(0, 3) == 0) begin
          a_r[i] = W'($urandom);
          b_r[i] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 40));
          req_r[i] = 1'b1;
        end else if (req_r[i] && $urandom_range(0, 29) == 0) req_r[i] = 1'b0;
      end
      step();
    end
    req_r = '0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Round-robin scheduler sharing one iterative divider (div_top: start/busy/valid/ov/dvz handshake) among NREQ requesters. Latches the winning requester's operands, pulses the divider start, waits for completion and routes quotient plus status flags back with the requester ID. A watchdog aborts any operation that never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 10, operand/quotient width
IDW, 2, requester ID width, clog2(NREQ)
TIMEOUT, 64, max cycles in WAIT before abort

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req  in  NREQ  per-requester request level; held with operands until gnt
a_in  in  NREQ*W  packed dividends, slice i = requester i
b_in  in  NREQ*W  packed divisors
gnt  out  NREQ  one-hot, 1-cycle pulse on operand capture
resp_valid  out  1  1-cycle pulse, response fields valid
resp_id  out  IDW  requester served
resp_q  out  W  quotient
resp_ov  out  1  divider overflow
resp_dvz  out  1  divide by zero
resp_to  out  1  watchdog abort
div_start  out  1  1-cycle start pulse to divider
div_a  out  W  registered dividend to divider
div_b  out  W  registered divisor to divider
div_q  in  W  divider quotient
div_busy  in  1  divider busy
div_valid  in  1  divider result valid
div_ov  in  1  divider overflow
div_dvz  in  1  divider divide-by-zero

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=0, all outputs 0, div_a/div_b=0, watchdog=0.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req, pick first set bit scanning from rr_ptr upward with wrap; capture its a/b into div_a/div_b, id into cur_id; gnt[id]=1 same cycle as capture; next ISSUE. No req: stay.
- ISSUE: div_start=1 for exactly one cycle; clear watchdog; next WAIT.
- WAIT: watchdog increments each cycle. Completion = div_valid | div_dvz | div_ov (any cycle in WAIT, including first). On completion latch div_q, div_ov, div_dvz into response regs, resp_to=0; next RESP. If watchdog reaches TIMEOUT-1 with no completion: resp_q=0, resp_to=1, flags 0; next RESP. Completion and timeout in same cycle: completion wins.
- RESP: resp_valid=1, resp_id=cur_id for one cycle; rr_ptr=(cur_id+1) mod NREQ; next IDLE.
- Latency: gnt to div_start 1 cycle; completion to resp_valid 1 cycle; min turnaround req->resp_valid = 3 cycles + divider latency.
- div_a/div_b held stable from capture until next capture (divider may sample late).
- Response fields hold until next RESP; only resp_valid pulses.
- Requester dropping req before gnt: simply not served; no error.
- req re-asserted by just-served requester in RESP cycle: considered only from next IDLE, with lowered priority per rr_ptr.
- div_valid etc. outside WAIT: ignored.
- Reset mid-operation: immediate return to IDLE, no resp_valid emitted; divider is reset by its own reset.
- No arithmetic performed here; divisor zero is forwarded, never short-circuited.

Decomposition:
- Shared package div_pkg: W default, state encoding constants (IDLE=0, ISSUE=1, WAIT=2, RESP=3), TIMEOUT default.
- One sub-module: rr_pick (combinational round-robin first-set-bit from pointer, outputs one-hot + index + any). Rest in div_arbiter.

Test Plan:
- Req0 only, A=848 (1101010000b), B=24 -> gnt[0], one div_start pulse, resp_valid with id=0, q=35, ov=0, dvz=0.
- Req1, A=32, B=16 -> resp id=1, q=2; gnt-to-div_start exactly 1 cycle.
- Req2, A=848, B=0; divider model asserts dvz -> resp id=2, dvz=1, to=0.
- req=4'b1111 held continuously, rr_ptr=0 -> service order 0,1,2,3,0; exactly one resp_valid per grant.
- Divider model never completes -> resp_to=1, q=0 after TIMEOUT cycles in WAIT; next request served normally.
- rst low during WAIT -> all outputs 0 immediately, no resp_valid; after release req3 served first with rr_ptr=0 scan giving id=3 when only req3 set.
